// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb
//  Description : Eight-entry register file with a three-state issue/execute/
//                write-back sequencer. Operand registers are presented to an
//                external ALU on A/B; the ALU result F and its flags are
//                buffered at the end of EXEC and retired in WB.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            : clock, synchronous active-high reset
//    issue_valid/ready   : operation handshake (ready only in IDLE)
//    ra/rb/rd_addr       : source A, source B, destination register index
//    wr_req, flag_req    : operation writes rd / updates status
//    A, B                : operands to the ALU
//    F, N, Z, C, V, D    : ALU result and flags
//    status              : registered flags {D,V,C,Z,N}
//    done                : one-cycle retire pulse (high throughout WB)
//  Configuration
//    R0_ZERO_EN          : when defined, R0 reads as zero and ignores writes
// ============================================================================
module regfile_wb #(
    parameter int BUS_WIDTH = 8,
    parameter int MSB       = BUS_WIDTH - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_valid,
    output logic         issue_ready,
    input  logic [2:0]   ra_addr,
    input  logic [2:0]   rb_addr,
    input  logic [2:0]   rd_addr,
    input  logic         wr_req,
    input  logic         flag_req,
    output logic [MSB:0] A,
    output logic [MSB:0] B,
    input  logic [MSB:0] F,
    input  logic         N,
    input  logic         Z,
    input  logic         C,
    input  logic         V,
    input  logic         D,
    output logic [4:0]   status,
    output logic         done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_WB   = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nx;

    logic [MSB:0] r_regs [0:7];
    logic [2:0]   r_ra;
    logic [2:0]   r_rb;
    logic [2:0]   r_rd;
    logic         r_wr;
    logic         r_flag;
    logic [MSB:0] r_f_buf;
    logic [4:0]   r_flags_buf;
    logic [4:0]   r_status;
    logic         w_wr_ok;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_IDLE:  if (issue_valid) w_state_nx = c_EXEC;
            c_EXEC:  w_state_nx = c_WB;
            c_WB:    w_state_nx = c_IDLE;
            default: w_state_nx = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        issue_ready = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_IDLE:  issue_ready = 1'b1;
            c_WB:    done        = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // R0 handling
    // ------------------------------------------------------------------
`ifdef R0_ZERO_EN
    assign w_wr_ok = (r_rd != 3'd0);
    assign A       = (r_ra == 3'd0) ? '0 : r_regs[r_ra];
    assign B       = (r_rb == 3'd0) ? '0 : r_regs[r_rb];
`else
    assign w_wr_ok = 1'b1;
    assign A       = r_regs[r_ra];
    assign B       = r_regs[r_rb];
`endif

    assign status = r_status;

    // ------------------------------------------------------------------
    // Datapath: operation latch, result buffer, register file, status.
    // Operand addresses stay latched after retire so A/B remain stable
    // until the next handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
            r_ra        <= 3'd0;
            r_rb        <= 3'd0;
            r_rd        <= 3'd0;
            r_wr        <= 1'b0;
            r_flag      <= 1'b0;
            r_f_buf     <= '0;
            r_flags_buf <= 5'd0;
            r_status    <= 5'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (issue_valid) begin
                        r_ra   <= ra_addr;
                        r_rb   <= rb_addr;
                        r_rd   <= rd_addr;
                        r_wr   <= wr_req;
                        r_flag <= flag_req;
                    end
                end
                c_EXEC: begin
                    r_f_buf     <= F;
                    r_flags_buf <= {D, V, C, Z, N};
                end
                c_WB: begin
                    if (r_wr && w_wr_ok) begin
                        r_regs[r_rd] <= r_f_buf;
                    end
                    if (r_flag) begin
                        r_status <= r_flags_buf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb
//  Description : Directed self-checking bench for regfile_wb. The bench
//                plays the ALU: either an 8-bit adder with flags, or a
//                forced result/flag value used to preload registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] ra_addr;
    logic [2:0] rb_addr;
    logic [2:0] rd_addr;
    logic       wr_req;
    logic       flag_req;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] F;
    logic       N, Z, C, V, D;
    logic [4:0] status;
    logic       done;

    int n_asserts = 0;
    int n_fails   = 0;
    int hs_cnt;
    int dn_cnt;

    // ALU model: add (FS=0000) or a forced value
    logic       force_en;
    logic [7:0] force_f;
    logic [4:0] force_flg;   // {D,V,C,Z,N}
    logic [8:0] sum;

    always_comb begin
        sum = {1'b0, A} + {1'b0, B};
        if (force_en) begin
            F = force_f;
            {D, V, C, Z, N} = force_flg;
        end else begin
            F = sum[7:0];
            N = sum[7];
            Z = (sum[7:0] == 8'h00);
            C = sum[8];
            V = (A[7] == B[7]) && (sum[7] != A[7]);
            D = 1'b0;
        end
    end

    regfile_wb dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .rd_addr    (rd_addr),
        .wr_req     (wr_req),
        .flag_req   (flag_req),
        .A          (A),
        .B          (B),
        .F          (F),
        .N          (N),
        .Z          (Z),
        .C          (C),
        .V          (V),
        .D          (D),
        .status     (status),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation: handshake, EXEC, WB, back to IDLE.
    // Inputs are scrambled after the handshake to show they are latched.
    task automatic op(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                      input logic wr, input logic fl,
                      input logic chk_ab, input logic [7:0] ea, input logic [7:0] eb);
        @(negedge clk);
        ra_addr = ra; rb_addr = rb; rd_addr = rd;
        wr_req = wr; flag_req = fl; issue_valid = 1'b1;
        chk("op_ready_idle", {7'd0, issue_ready}, 8'd1);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        ra_addr = ~ra; rb_addr = ~rb; rd_addr = ~rd;
        wr_req = ~wr; flag_req = ~fl;
        @(negedge clk);                                   // EXEC
        chk("op_ready_exec", {7'd0, issue_ready}, 8'd0);
        chk("op_done_exec",  {7'd0, done},        8'd0);
        if (chk_ab) begin
            chk("op_a_exec", A, ea);
            chk("op_b_exec", B, eb);
        end
        @(negedge clk);                                   // WB
        chk("op_done_wb",  {7'd0, done},        8'd1);
        chk("op_ready_wb", {7'd0, issue_ready}, 8'd0);
        @(negedge clk);                                   // IDLE
        chk("op_done_idle",  {7'd0, done},        8'd0);
        chk("op_ready_idle", {7'd0, issue_ready}, 8'd1);
        if (chk_ab && !wr) begin
            chk("op_a_hold", A, ea);
            chk("op_b_hold", B, eb);
        end
    endtask

    task automatic preload(input logic [2:0] rd, input logic [7:0] val);
        force_en = 1'b1; force_f = val; force_flg = 5'b11111;
        op(3'd0, 3'd0, rd, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        force_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0;
        ra_addr = 3'd0; rb_addr = 3'd0; rd_addr = 3'd0;
        wr_req = 1'b0; flag_req = 1'b0;
        force_en = 1'b0; force_f = 8'h00; force_flg = 5'd0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",  {7'd0, issue_ready}, 8'd1);
        chk("rst_status", {3'd0, status},      8'h00);
        chk("rst_a",      A,                   8'h00);
        chk("rst_b",      B,                   8'h00);
        chk("rst_done",   {7'd0, done},        8'd0);

        // R1=5, R2=3, then R3 = R1 + R2 with flags
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);
        chk("preload_status_hold", {3'd0, status}, 8'h00);
        op(3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 8'h05, 8'h03);
        chk("add_status", {3'd0, status}, 8'h00);
        op(3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h08);

        // flag_req=0 with Z=1: register written, status held
        force_en = 1'b1; force_f = 8'h5A; force_flg = 5'b00010;
        op(3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        force_en = 1'b0;
        chk("noflag_status", {3'd0, status}, 8'h00);
        op(3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h5A);

        // FF + 01 = 00 with carry and zero -> {D,V,C,Z,N} = 00110
        preload(3'd5, 8'hFF);
        preload(3'd6, 8'h01);
        op(3'd5, 3'd6, 3'd1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h01);
        chk("carry_status", {3'd0, status}, 8'h06);
        op(3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h03);

        // issue_valid held high for 6 cycles
        @(negedge clk);
        ra_addr = 3'd5; rb_addr = 3'd6; rd_addr = 3'd0;
        wr_req = 1'b0; flag_req = 1'b0; issue_valid = 1'b1;
        hs_cnt = 0; dn_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            chk("b2b_ready", {7'd0, issue_ready}, (i % 3 == 0) ? 8'd1 : 8'd0);
            chk("b2b_done",  {7'd0, done},        (i % 3 == 2) ? 8'd1 : 8'd0);
            if (issue_ready) hs_cnt++;
            if (done) dn_cnt++;
            if (i < 5) @(negedge clk);
        end
        @(posedge clk);
        #1 issue_valid = 1'b0;
        chk("b2b_handshakes", hs_cnt[7:0], 8'd2);
        chk("b2b_dones",      dn_cnt[7:0], 8'd2);
        @(negedge clk);
        chk("b2b_end_ready", {7'd0, issue_ready}, 8'd1);
        chk("b2b_end_done",  {7'd0, done},        8'd0);

        // Reset during EXEC of a write to R4 aborts it
        force_en = 1'b1; force_f = 8'h77; force_flg = 5'b11111;
        @(negedge clk);
        ra_addr = 3'd0; rb_addr = 3'd0; rd_addr = 3'd4;
        wr_req = 1'b1; flag_req = 1'b1; issue_valid = 1'b1;
        @(posedge clk);
        #1 issue_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        force_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_done",  {7'd0, done},        8'd0);
            chk("abort_ready", {7'd0, issue_ready}, 8'd1);
        end
        chk("abort_status", {3'd0, status}, 8'h00);
        op(3'd4, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

        // R0 write followed by read
        preload(3'd0, 8'hAA);
`ifdef R0_ZERO_EN
        op(3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
`else
        op(3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 8'hAA, 8'hAA);
`endif
        chk("r0_status_hold", {3'd0, status}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter BUS_WIDTH, default 8: width of register contents, A, B and F.
REQ-002 Parameter MSB, default BUS_WIDTH-1: index of the top data bit.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 issue_valid  input  1: an operation is offered this cycle.
REQ-006 issue_ready  output  1: block accepts an operation this cycle.
REQ-007 ra_addr  input  3: source register index for operand A.
REQ-008 rb_addr  input  3: source register index for operand B.
REQ-009 rd_addr  input  3: destination register index.
REQ-010 wr_req  input  1: the offered operation writes rd_addr.
REQ-011 flag_req  input  1: the offered operation updates the status register.
REQ-012 A  output  BUS_WIDTH: operand A to the ALU.
REQ-013 B  output  BUS_WIDTH: operand B to the ALU.
REQ-014 F  input  BUS_WIDTH: ALU result.
REQ-015 N, Z, C, V, D  input  1 each: ALU flags.
REQ-016 status  output  5: registered flags {D,V,C,Z,N}.
REQ-017 done  output  1: one-cycle pulse when an operation retires.

Function
REQ-018 The block SHALL hold 8 registers of BUS_WIDTH bits, R0..R7.
REQ-019 The FSM SHALL have three states: IDLE, EXEC and WB.
REQ-020 issue_ready SHALL be 1 in IDLE only and 0 in EXEC and WB.
REQ-021 In IDLE, issue_valid=1 SHALL be a handshake: latch ra_addr, rb_addr, rd_addr, wr_req and flag_req, then go to EXEC.
REQ-022 In IDLE with issue_valid=0, the FSM SHALL stay in IDLE and no state other than the FSM SHALL change.
REQ-023 Inputs offered while issue_ready=0 SHALL be ignored.
REQ-024 In EXEC, A and B SHALL combinationally show the registers named by the latched ra_addr and rb_addr.
REQ-025 At the end of EXEC, F and N, Z, C, V, D SHALL be captured into an internal result buffer, and the FSM SHALL go to WB.
REQ-026 In IDLE and WB, A and B SHALL keep showing the latched-address registers, giving stable ALU inputs.
REQ-027 In WB, if the latched wr_req=1, the buffered F SHALL be written to the latched rd_addr.
REQ-028 In WB, if the latched flag_req=1, status SHALL load the buffered {D,V,C,Z,N}; otherwise status SHALL hold.
REQ-029 In WB, done SHALL be asserted for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-030 Latency: handshake at edge t, register and status update at edge t+2, done high during the cycle between edges t+1 and t+2.
REQ-031 Back-to-back throughput SHALL be one operation per 3 cycles; the next handshake is possible in the cycle after WB.
REQ-032 When a source register equals the prior operation's destination, the newly written value SHALL be read, because the write completes before the next EXEC.
REQ-033 ra_addr = rb_addr SHALL present the same register on both A and B.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE, clear R0..R7 to 0, status to 5'b00000, done to 0, the latched addresses and flags to 0 and the result buffer to 0.
REQ-035 Reset in EXEC or WB SHALL abort the operation: no register write, no status update, no done pulse.
REQ-036 issue_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-037 Macro R0_ZERO_EN SHALL control R0 behaviour.
REQ-038 With R0_ZERO_EN defined, reads of R0 SHALL return 0 and writes to R0 SHALL be discarded; done and status SHALL behave normally.
REQ-039 Without R0_ZERO_EN, R0 SHALL be an ordinary read/write register.

Verification
REQ-040 Reset then idle -> issue_ready=1, status=00000, A=B=0, done=0.
REQ-041 Preload R1=8'h05 and R2=8'h03; issue ra=1, rb=2, rd=3, wr_req=1, flag_req=1 with an ALU model of FS=0000 -> at t+2 R3=8'h08, status=00000, done pulse seen once.
REQ-042 issue_valid held high for 6 cycles -> exactly 2 handshakes and 2 done pulses, with issue_ready low in EXEC and WB.
REQ-043 rst asserted during EXEC of a write to R4 -> R4 stays 0, no done pulse, state is IDLE.
REQ-044 With R0_ZERO_EN: a write of 8'hAA to R0 followed by a read of R0 -> A=8'h00; without it -> A=8'hAA.
REQ-045 An operation with flag_req=0 and an ALU Z=1 -> status unchanged; the register is still written if wr_req=1.
